// File: rtl/dtack_pkg.sv
// Shared types and widths for the 68000 DTACK/BERR generator.
// Holds the FSM state enum, counter widths and the region select encoding.
package dtack_pkg;

  localparam int WS_W = 4;
  localparam int TO_W = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WAIT  = 3'd1,
    ACK   = 3'd2,
    UNMAP = 3'd3,
    ERR   = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    RGN_NONE = 2'd0,
    RGN_ROM  = 2'd1,
    RGN_RAM  = 2'd2,
    RGN_IO   = 2'd3
  } region_t;

  // Fixed priority ROM > RAM > IO when decodes overlap.
  function automatic region_t region_sel(input logic rom, input logic ram, input logic io);
    if (rom) begin
      return RGN_ROM;
    end else if (ram) begin
      return RGN_RAM;
    end else if (io) begin
      return RGN_IO;
    end
    return RGN_NONE;
  endfunction

endpackage

// File: rtl/dtack_gen_bus_watchdog.sv
// Unmapped-access watchdog: saturating CPU-tick counter and timeout compare.
// Only instantiated by dtack_gen when BUS_TIMEOUT_EN is defined.
module bus_watchdog
  import dtack_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk_in,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam logic [TO_W-1:0] LIMIT = TO_W'(TIMEOUT_CYCLES);

  logic [TO_W-1:0] cnt;

  function automatic logic [TO_W-1:0] sat_inc(input logic [TO_W-1:0] v);
    return (v == {TO_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= sat_inc(cnt);
    end
  end

  assign expired = (cnt >= LIMIT);

endmodule

// File: rtl/dtack_gen.sv
// 68000 DTACK/BERR generator with per-region wait states counted in CPU clocks.
// Optional unmapped-access bus error is enabled by defining BUS_TIMEOUT_EN.
module dtack_gen
  import dtack_pkg::*;
#(
  parameter int WS_ROM         = 2,
  parameter int WS_RAM         = 0,
  parameter int WS_IO          = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk_in,
  input  logic reset,
  input  logic cpu_clk,
  input  logic as_n,
  input  logic cs_rom,
  input  logic cs_ram,
  input  logic cs_io,
  output logic dtack_n,
  output logic berr_n,
  output logic busy
);

  if (WS_ROM < 0 || WS_ROM > 15) begin : g_bad_ws_rom
    $error("dtack_gen: WS_ROM must be in 0..15");
  end
  if (WS_RAM < 0 || WS_RAM > 15) begin : g_bad_ws_ram
    $error("dtack_gen: WS_RAM must be in 0..15");
  end
  if (WS_IO < 0 || WS_IO > 15) begin : g_bad_ws_io
    $error("dtack_gen: WS_IO must be in 0..15");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("dtack_gen: TIMEOUT_CYCLES must be in 1..255");
  end

  state_t          state;
  logic [WS_W-1:0] wcnt;
  logic            as_n_p1;
  logic            cpu_clk_p1;
  logic            cpu_tick;
  logic            to_expired;
  region_t         rgn;

  function automatic logic [WS_W-1:0] region_ws(input region_t r);
    case (r)
      RGN_ROM: region_ws = WS_W'(WS_ROM);
      RGN_RAM: region_ws = WS_W'(WS_RAM);
      RGN_IO:  region_ws = WS_W'(WS_IO);
      default: region_ws = '0;
    endcase
  endfunction

  // Stage p1: strobe register and CPU clock edge detect (same clock domain).
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      as_n_p1    <= 1'b1;
      cpu_clk_p1 <= 1'b0;
    end else begin
      as_n_p1    <= as_n;
      cpu_clk_p1 <= cpu_clk;
    end
  end

  assign cpu_tick = cpu_clk & ~cpu_clk_p1;
  assign rgn      = region_sel(cs_rom, cs_ram, cs_io);

`ifdef BUS_TIMEOUT_EN
  logic to_clr;
  logic to_inc;

  // Held clear while idle so every unmapped access starts counting from zero.
  assign to_clr = (state == IDLE);
  assign to_inc = (state == UNMAP) & cpu_tick;

  bus_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_in (clk_in),
    .reset  (reset),
    .clr    (to_clr),
    .inc    (to_inc),
    .expired(to_expired)
  );
`else
  assign to_expired = 1'b0;
`endif

  // Stage p2: bus cycle FSM with registered DTACK/BERR/busy.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      wcnt    <= '0;
      dtack_n <= 1'b1;
      berr_n  <= 1'b1;
      busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!as_n_p1) begin
            busy <= 1'b1;
            if (rgn == RGN_NONE) begin
              state <= UNMAP;
            end else begin
              state <= WAIT;
              wcnt  <= region_ws(rgn);
            end
          end
        end
        WAIT: begin
          if (as_n_p1) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (wcnt == '0) begin
            state   <= ACK;
            dtack_n <= 1'b0;
          end else if (cpu_tick) begin
            wcnt <= wcnt - 1'b1;
          end
        end
        ACK: begin
          if (as_n_p1) begin
            state   <= IDLE;
            dtack_n <= 1'b1;
            busy    <= 1'b0;
          end
        end
        UNMAP: begin
          if (as_n_p1) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (to_expired) begin
            state  <= ERR;
            berr_n <= 1'b0;
          end
        end
        ERR: begin
          if (as_n_p1) begin
            state  <= IDLE;
            berr_n <= 1'b1;
            busy   <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          dtack_n <= 1'b1;
          berr_n  <= 1'b1;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dtack_gen.sv
// Bench for dtack_gen: behavioural access model checked every cycle, plus fixed-latency
// scenarios with hand-computed edge counts and randomized access sequences.
module tb_dtack_gen;

  localparam int WS_ROM         = 2;
  localparam int WS_RAM         = 0;
  localparam int WS_IO          = 4;
  localparam int TIMEOUT_CYCLES = 64;
`ifdef BUS_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  // Model phases of a bus access.
  localparam int P_IDLE  = 0;
  localparam int P_WAIT  = 1;
  localparam int P_ACK   = 2;
  localparam int P_UNMAP = 3;
  localparam int P_ERR   = 4;

  logic clk_in  = 1'b0;
  logic reset   = 1'b1;
  logic cpu_clk = 1'b1;
  logic as_n    = 1'b1;
  logic cs_rom  = 1'b0;
  logic cs_ram  = 1'b0;
  logic cs_io   = 1'b0;
  logic dtack_n;
  logic berr_n;
  logic busy;

  int cdiv   = 0;
  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  int   m_phase = P_IDLE;
  int   m_need  = 0;
  int   m_ticks = 0;
  int   m_to    = 0;
  logic m_asr   = 1'b1;
  logic m_cpr   = 1'b0;

  dtack_gen #(
    .WS_ROM        (WS_ROM),
    .WS_RAM        (WS_RAM),
    .WS_IO         (WS_IO),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk_in (clk_in),
    .reset  (reset),
    .cpu_clk(cpu_clk),
    .as_n   (as_n),
    .cs_rom (cs_rom),
    .cs_ram (cs_ram),
    .cs_io  (cs_io),
    .dtack_n(dtack_n),
    .berr_n (berr_n),
    .busy   (busy)
  );

  always #10 clk_in = ~clk_in;

  // 50 MHz / 10 CPU clock, high for 5 of 10 cycles; rises on the edge that sets cdiv to 0.
  always @(posedge clk_in) begin
    cdiv    <= (cdiv + 1) % 10;
    cpu_clk <= (((cdiv + 1) % 10) < 5);
  end

  task automatic model_step();
    bit tick;
    tick = cpu_clk && !m_cpr;
    case (m_phase)
      P_IDLE: begin
        if (!m_asr) begin
          m_ticks = 0;
          m_to    = 0;
          if (cs_rom) begin
            m_need = WS_ROM; m_phase = P_WAIT;
          end else if (cs_ram) begin
            m_need = WS_RAM; m_phase = P_WAIT;
          end else if (cs_io) begin
            m_need = WS_IO; m_phase = P_WAIT;
          end else begin
            m_phase = P_UNMAP;
          end
        end
      end
      P_WAIT: begin
        if (m_asr) m_phase = P_IDLE;
        else if (m_ticks >= m_need) m_phase = P_ACK;
        else if (tick) m_ticks++;
      end
      P_ACK: if (m_asr) m_phase = P_IDLE;
      P_UNMAP: begin
        if (m_asr) m_phase = P_IDLE;
        else if (TO_EN && m_to >= TIMEOUT_CYCLES) m_phase = P_ERR;
        else if (tick && m_to < 255) m_to++;
      end
      P_ERR: if (m_asr) m_phase = P_IDLE;
      default: m_phase = P_IDLE;
    endcase
    m_asr = as_n;
    m_cpr = cpu_clk;
  endtask

  initial begin
    forever begin
      @(posedge clk_in or posedge reset);
      if (reset) begin
        m_phase = P_IDLE;
        m_asr   = 1'b1;
        m_cpr   = 1'b0;
        m_ticks = 0;
        m_to    = 0;
      end else begin
        model_step();
      end
    end
  end

  task automatic cmp(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%b expected=%b", name, $time, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk_in);
      if (cmp_en) begin
        cmp("cyc_dtack_n", dtack_n, m_phase != P_ACK);
        cmp("cyc_berr_n", berr_n, m_phase != P_ERR);
        cmp("cyc_busy", busy, m_phase != P_IDLE);
        cmp("cyc_not_both_low", dtack_n | berr_n, 1'b1);
      end
    end
  end

  // Literal expectation checked against both the DUT and the model.
  task automatic lit(input string name, input logic act, input logic mdl, input logic exp);
    cmp({name, "_dut"}, act, exp);
    cmp({name, "_model"}, mdl, exp);
  endtask

  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  task automatic cycn(input int n);
    repeat (n) cyc();
  endtask

  task automatic align();
    cyc();
    while (cdiv != 1) cyc();
  endtask

  task automatic release_bus();
    as_n   = 1'b1;
    cs_rom = 1'b0;
    cs_ram = 1'b0;
    cs_io  = 1'b0;
    cycn(4);
  endtask

  task automatic rand_cs();
    logic [2:0] r;
    r = 3'($urandom_range(0, 7));
    if ($urandom_range(0, 4) == 0) r = 3'b000;
    {cs_rom, cs_ram, cs_io} = r;
  endtask

  task automatic random_phase();
    int hold;
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 9) == 0) hold = $urandom_range(600, 700);
      else hold = $urandom_range(1, 60);
      as_n = 1'b0;
      rand_cs();
      for (int k = 0; k < hold; k++) begin
        cyc();
        rand_cs();
      end
      as_n = 1'b1;
      cycn($urandom_range(1, 4));
    end
    release_bus();
  endtask

  initial begin
    cycn(3);
    lit("rst_dtack_n", dtack_n, m_phase != P_ACK, 1'b1);
    lit("rst_berr_n", berr_n, m_phase != P_ERR, 1'b1);
    lit("rst_busy", busy, m_phase != P_IDLE, 1'b0);
    reset  = 1'b0;
    cmp_en = 1'b1;
    cycn(3);

    // RAM, zero wait states: low two edges after the strobe is registered.
    align();
    cs_ram = 1'b1; as_n = 1'b0;
    cycn(2);
    lit("ram_before", dtack_n, m_phase != P_ACK, 1'b1);
    cyc();
    lit("ram_ack", dtack_n, m_phase != P_ACK, 1'b0);
    cycn(7);
    as_n = 1'b1; cs_ram = 1'b0;
    cyc();
    lit("ram_rel_hold", dtack_n, m_phase != P_ACK, 1'b0);
    cyc();
    lit("ram_rel_done", dtack_n, m_phase != P_ACK, 1'b1);
    lit("ram_rel_busy", busy, m_phase != P_IDLE, 1'b0);
    release_bus();

    // IO, four ticks after WAIT entry.
    align();
    cs_io = 1'b1; as_n = 1'b0;
    cycn(40);
    lit("io_before", dtack_n, m_phase != P_ACK, 1'b1);
    cyc();
    lit("io_ack", dtack_n, m_phase != P_ACK, 1'b0);
    release_bus();

    // ROM and IO decoded together: ROM timing wins.
    align();
    cs_rom = 1'b1; cs_io = 1'b1; as_n = 1'b0;
    cycn(20);
    lit("romio_before", dtack_n, m_phase != P_ACK, 1'b1);
    cyc();
    lit("romio_ack", dtack_n, m_phase != P_ACK, 1'b0);
    release_bus();

    // IO aborted after two ticks, then an immediate RAM access.
    align();
    cs_io = 1'b1; as_n = 1'b0;
    cycn(25);
    as_n = 1'b1; cs_io = 1'b0;
    cyc();
    lit("abort_busy_hold", busy, m_phase != P_IDLE, 1'b1);
    as_n = 1'b0; cs_ram = 1'b1;
    cyc();
    lit("abort_idle", busy, m_phase != P_IDLE, 1'b0);
    lit("abort_no_ack", dtack_n, m_phase != P_ACK, 1'b1);
    cyc();
    lit("next_busy", busy, m_phase != P_IDLE, 1'b1);
    cyc();
    lit("next_ack", dtack_n, m_phase != P_ACK, 1'b0);
    release_bus();

    // Unmapped access held low past the timeout.
    align();
    as_n = 1'b0;
    cycn(640);
    lit("unmap_before", berr_n, m_phase != P_ERR, 1'b1);
    cyc();
    lit("unmap_berr", berr_n, m_phase != P_ERR, !TO_EN);
    lit("unmap_dtack", dtack_n, m_phase != P_ACK, 1'b1);
    lit("unmap_busy", busy, m_phase != P_IDLE, 1'b1);
    release_bus();

    // Asynchronous reset while acknowledging.
    align();
    cs_ram = 1'b1; as_n = 1'b0;
    cycn(5);
    lit("rack_ack", dtack_n, m_phase != P_ACK, 1'b0);
    reset = 1'b1;
    #1;
    lit("rack_dtack_n", dtack_n, m_phase != P_ACK, 1'b1);
    lit("rack_busy", busy, m_phase != P_IDLE, 1'b0);
    lit("rack_berr_n", berr_n, m_phase != P_ERR, 1'b1);
    cyc();
    reset = 1'b0;
    release_bus();

    random_phase();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
